// File: rtl/fnd_scan_mux.sv
// Self-scanning digit multiplexer for a multi-digit 7-segment (FND) display.
// A full frame of digits is snapshotted at the frame boundary so a changing count never tears.
module fnd_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_LZ   = 1,
  parameter int POS_W      = $clog2(NUM_DIGITS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]         i_dp,
  output logic [POS_W-1:0]              o_digitPosition,
  output logic [DIGIT_W-1:0]            o_value,
  output logic                          o_blank,
  output logic                          o_dp,
  output logic [NUM_DIGITS-1:0]         o_fndCom,
  output logic                          o_tick
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DATA_W = NUM_DIGITS * DIGIT_W;

  logic [DIV_W-1:0]      divCnt_q, divCnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [DATA_W-1:0]     snapDigits_q, snapDigits_d;
  logic [NUM_DIGITS-1:0] snapDp_q, snapDp_d;

  logic                  active;
  logic                  slotEnd;
  logic                  frameEnd;
  logic                  upperZero;
  logic [NUM_DIGITS-1:0] lzBlank;
  logic [DIGIT_W-1:0]    valueSel;
  logic                  blankSel;
  logic                  dpSel;

  // Reset also forces the display dark, not just the state registers.
  assign active   = i_enable & ~i_reset;
  assign slotEnd  = (divCnt_q == DIV_W'(SCAN_DIV - 1));
  assign frameEnd = slotEnd & (pos_q == POS_W'(NUM_DIGITS - 1));

  always_comb begin
    divCnt_d     = divCnt_q;
    pos_d        = pos_q;
    snapDigits_d = snapDigits_q;
    snapDp_d     = snapDp_q;
    if (i_enable) begin
      if (slotEnd) begin
        divCnt_d = '0;
        pos_d    = frameEnd ? '0 : pos_q + POS_W'(1);
      end else begin
        divCnt_d = divCnt_q + DIV_W'(1);
      end
      if (frameEnd) begin
        snapDigits_d = i_digits;
        snapDp_d     = i_dp;
      end
    end else begin
      snapDigits_d = i_digits;
      snapDp_d     = i_dp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      divCnt_q     <= '0;
      pos_q        <= '0;
      snapDigits_q <= '0;
      snapDp_q     <= '0;
    end else begin
      divCnt_q     <= divCnt_d;
      pos_q        <= pos_d;
      snapDigits_q <= snapDigits_d;
      snapDp_q     <= snapDp_d;
    end
  end

  // Walk down from the top digit; a digit is a leading zero while everything above it is zero.
  always_comb begin
    lzBlank   = '0;
    upperZero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upperZero  = upperZero & (snapDigits_q[k*DIGIT_W +: DIGIT_W] == '0);
      lzBlank[k] = upperZero & ~snapDp_q[k];
    end
  end

  always_comb begin
    valueSel = '0;
    blankSel = 1'b0;
    dpSel    = 1'b0;
    o_fndCom = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (pos_q == POS_W'(k)) begin
        valueSel    = snapDigits_q[k*DIGIT_W +: DIGIT_W];
        blankSel    = lzBlank[k];
        dpSel       = snapDp_q[k];
        o_fndCom[k] = ~active;
      end
    end
  end

  assign o_digitPosition = pos_q;
  assign o_value         = valueSel;
  assign o_blank         = ~active | ((BLANK_LZ != 0) & blankSel);
  assign o_dp            = dpSel & active;
  assign o_tick          = active & slotEnd;

endmodule

// File: tb/tb_fnd_scan_mux.sv
// Randomized, model-checked bench for fnd_scan_mux (4-digit/div-4 and 6-digit/div-1 instances).
module tb_fnd_scan_mux;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int FRAME = N * S;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset4, enable4;
  logic [15:0] digits4;
  logic [3:0]  dp4;
  logic [1:0]  pos4;
  logic [3:0]  value4;
  logic        blank4, dpOut4, tick4;
  logic [3:0]  com4;

  logic        reset6, enable6;
  logic [23:0] digits6;
  logic [5:0]  dp6;
  logic [2:0]  pos6;
  logic [3:0]  value6;
  logic        blank6, dpOut6, tick6;
  logic [5:0]  com6;

  int checks = 0;
  int passed = 0;

  // Reference model: enabled cycles since reset plus the digits currently on display.
  int          elapsed;
  logic [15:0] shownDigits;
  logic [3:0]  shownDp;
  logic [12:0] expVec;
  logic [12:0] gotVec;

  fnd_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut4 (
    .i_clk(clk), .i_reset(reset4), .i_enable(enable4), .i_digits(digits4), .i_dp(dp4),
    .o_digitPosition(pos4), .o_value(value4), .o_blank(blank4), .o_dp(dpOut4),
    .o_fndCom(com4), .o_tick(tick4)
  );

  fnd_scan_mux #(.NUM_DIGITS(6), .DIGIT_W(4), .SCAN_DIV(1), .BLANK_LZ(1)) dut6 (
    .i_clk(clk), .i_reset(reset6), .i_enable(enable6), .i_digits(digits6), .i_dp(dp6),
    .o_digitPosition(pos6), .o_value(value6), .o_blank(blank6), .o_dp(dpOut6),
    .o_fndCom(com6), .o_tick(tick6)
  );

  task automatic cycle4();
    int  k;
    bit  act;
    bit  lz;
    logic [3:0] expCom;
    @(posedge clk);
    if (reset4) begin
      elapsed     = 0;
      shownDigits = '0;
      shownDp     = '0;
    end else if (enable4) begin
      if (elapsed % FRAME == FRAME - 1) begin
        shownDigits = digits4;
        shownDp     = dp4;
      end
      elapsed++;
    end else begin
      shownDigits = digits4;
      shownDp     = dp4;
    end
    #1;
    k      = (elapsed / S) % N;
    act    = enable4 && !reset4;
    lz     = (k > 0) && ((shownDigits >> (4 * k)) == 16'h0) && !shownDp[k];
    expCom = act ? ~(4'b0001 << k) : 4'hF;
    expVec = {2'(k), shownDigits[4*k +: 4], !act || lz, shownDp[k] && act, expCom,
              act && (elapsed % S == S - 1)};
    gotVec = {pos4, value4, blank4, dpOut4, com4, tick4};
  endtask

  task automatic test_reset();
    reset4  = 1'b1;
    enable4 = 1'b1;
    digits4 = 16'h1234;
    dp4     = 4'h0;
    for (int i = 0; i < 2; i++) begin
      cycle4();
      checks++;
      if (gotVec !== expVec) $display("[TB] FAIL reset_model: got %h required %h", gotVec, expVec);
      else passed++;
    end
    checks++;
    if ({pos4, value4, blank4, dpOut4, com4, tick4} !== {2'd0, 4'd0, 1'b1, 1'b0, 4'hF, 1'b0})
      $display("[TB] FAIL reset_state: got %h required %h",
               {pos4, value4, blank4, dpOut4, com4, tick4}, {2'd0, 4'd0, 1'b1, 1'b0, 4'hF, 1'b0});
    else passed++;
  endtask

  task automatic test_scan();
    int ticks = 0;
    logic [3:0] comSeq [4];
    reset4 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      cycle4();
      ticks += int'(tick4);
      if (i >= 16 && i < 32 && (i % 4) == 0) comSeq[(i / 4) % 4] = com4;
      checks++;
      if (gotVec !== expVec) $display("[TB] FAIL scan_model cycle %0d: got %h required %h", i, gotVec, expVec);
      else passed++;
    end
    checks++;
    if (ticks != 8) $display("[TB] FAIL scan_tick_count: got %0d required 8", ticks);
    else passed++;
    checks++;
    if ({comSeq[0], comSeq[1], comSeq[2], comSeq[3]} !== 16'hEDB7)
      $display("[TB] FAIL scan_com_sequence: got %h required edb7",
               {comSeq[0], comSeq[1], comSeq[2], comSeq[3]});
    else passed++;
  endtask

  task automatic test_blanking();
    logic [15:0] caseDigits [3] = '{16'h0050, 16'h0000, 16'h0050};
    logic [3:0]  caseDp     [3] = '{4'b0000, 4'b0000, 4'b0100};
    logic [3:0]  caseBlank  [3] = '{4'b1100, 4'b1110, 4'b1000};
    logic [3:0]  caseDpOut  [3] = '{4'b0000, 4'b0000, 4'b0100};
    logic [3:0]  blankBits, dpBits;
    for (int c = 0; c < 3; c++) begin
      digits4 = caseDigits[c];
      dp4     = caseDp[c];
      for (int b = 0; b < 40; b++) begin
        cycle4();
        if (elapsed % FRAME == 0) break;
      end
      checks++;
      if (elapsed % FRAME != 0) $display("[TB] FAIL blank_align: got %0d required 0", elapsed % FRAME);
      else passed++;
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) cycle4();
        blankBits[pos4] = blank4;
        dpBits[pos4]    = dpOut4;
        checks++;
        if (gotVec !== expVec) $display("[TB] FAIL blank_model: got %h required %h", gotVec, expVec);
        else passed++;
      end
      checks++;
      if ({blankBits, dpBits} !== {caseBlank[c], caseDpOut[c]})
        $display("[TB] FAIL blank_case%0d: got %h required %h", c, {blankBits, dpBits},
                 {caseBlank[c], caseDpOut[c]});
      else passed++;
    end
    dp4 = 4'h0;
  endtask

  task automatic test_tearing();
    logic [3:0] vals [4];
    digits4 = 16'h1234;
    for (int b = 0; b < 40; b++) begin
      cycle4();
      if (elapsed % FRAME == 0) break;
    end
    for (int i = 0; i < 8; i++) cycle4();
    digits4 = 16'h5678;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cycle4();
      vals[pos4] = value4;
      checks++;
      if (gotVec !== expVec) $display("[TB] FAIL tear_model: got %h required %h", gotVec, expVec);
      else passed++;
    end
    checks++;
    if ({vals[3], vals[2]} !== 8'h12) $display("[TB] FAIL tear_old_frame: got %h required 12", {vals[3], vals[2]});
    else passed++;
    for (int i = 0; i < FRAME; i++) begin
      cycle4();
      vals[pos4] = value4;
      checks++;
      if (gotVec !== expVec) $display("[TB] FAIL tear_model_next: got %h required %h", gotVec, expVec);
      else passed++;
    end
    checks++;
    if ({vals[3], vals[2], vals[1], vals[0]} !== 16'h5678)
      $display("[TB] FAIL tear_new_frame: got %h required 5678", {vals[3], vals[2], vals[1], vals[0]});
    else passed++;
  endtask

  task automatic test_enable();
    for (int b = 0; b < 40; b++) begin
      cycle4();
      if (elapsed % FRAME == 6) break;
    end
    checks++;
    if (elapsed % FRAME != 6) $display("[TB] FAIL enable_align: got %0d required 6", elapsed % FRAME);
    else passed++;
    enable4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle4();
      checks++;
      if (gotVec !== expVec || pos4 !== 2'd1 || com4 !== 4'hF || blank4 !== 1'b1)
        $display("[TB] FAIL enable_hold: got %h required %h", gotVec, expVec);
      else passed++;
    end
    enable4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle4();
      checks++;
      if (gotVec !== expVec) $display("[TB] FAIL enable_resume: got %h required %h", gotVec, expVec);
      else passed++;
    end
    checks++;
    if (pos4 !== 2'd2) $display("[TB] FAIL enable_slot_done: got %0d required 2", pos4);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 40; b++) begin
      cycle4();
      if ((elapsed / S) % N == 3 && elapsed % S == 1) break;
    end
    reset4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle4();
      checks++;
      if (gotVec !== expVec || com4 !== 4'hF || blank4 !== 1'b1 || pos4 !== 2'd0)
        $display("[TB] FAIL reset_mid: got %h required %h", gotVec, expVec);
      else passed++;
    end
    reset4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle4();
      checks++;
      if (gotVec !== expVec) $display("[TB] FAIL reset_mid_restart: got %h required %h", gotVec, expVec);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) digits4 = 16'($urandom) >> (4 * $urandom_range(3));
      if ($urandom_range(7) == 0) dp4 = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      enable4 = ($urandom_range(9) != 0);
      reset4  = ($urandom_range(99) == 0);
      cycle4();
      checks++;
      if (gotVec !== expVec) $display("[TB] FAIL random_model cycle %0d: got %h required %h", i, gotVec, expVec);
      else passed++;
    end
    reset4  = 1'b0;
    enable4 = 1'b1;
  endtask

  task automatic test_six_digits();
    reset6  = 1'b1;
    enable6 = 1'b1;
    digits6 = 24'($urandom);
    @(posedge clk);
    #1;
    checks++;
    if ({pos6, tick6, com6} !== {3'd0, 1'b0, 6'h3F})
      $display("[TB] FAIL six_reset: got %h required %h", {pos6, tick6, com6}, {3'd0, 1'b0, 6'h3F});
    else passed++;
    reset6 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({pos6, tick6, com6} !== {3'(i % 6), 1'b1, ~(6'b000001 << (i % 6))})
        $display("[TB] FAIL six_scan cycle %0d: got %h required %h", i, {pos6, tick6, com6},
                 {3'(i % 6), 1'b1, ~(6'b000001 << (i % 6))});
      else passed++;
    end
  endtask

  initial begin
    reset6      = 1'b1;
    enable6     = 1'b0;
    digits6     = '0;
    dp6         = '0;
    elapsed     = 0;
    shownDigits = '0;
    shownDp     = '0;
    test_reset();
    test_scan();
    test_blanking();
    test_tearing();
    test_enable();
    test_reset_mid();
    test_random();
    test_six_digits();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
